// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - N-channel round-robin stream arbiter with priority tiers, hold and burst cap
// Merges FWFT channel FIFOs into one registered output word with a source channel tag.
module stream_rr_arbiter #(
    parameter int                WIDTH      = 8,
    parameter int                DATA_WIDTH = 32,
    parameter logic [WIDTH-1:0]  PRIORITY   = '0,
    parameter int                MAX_BURST  = 256,
    localparam int               CH_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [WIDTH-1:0]            WRITE_REQ,
    input  logic [WIDTH-1:0]            HOLD_REQ,
    input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0]            READ_GRANT,
    input  logic                        READY_IN,
    output logic                        VALID_OUT,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic [CH_W-1:0]             CHANNEL_OUT,
    output logic                        BUSY
);

    localparam logic [15:0] BURST_CAP = 16'(MAX_BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [CH_W-1:0]  g;
    logic [CH_W-1:0]  last;
    logic [15:0]      burst_cnt;

    logic [WIDTH-1:0] cand;
    logic [CH_W-1:0]  winner;
    logic             found;
    logic             burst_hit;
    logic             pop;

    // Hold requests outrank everything, then the priority tier, then plain requests.
    always_comb begin
        cand = WRITE_REQ;
        if (|HOLD_REQ)
            cand = HOLD_REQ;
        else if (|(WRITE_REQ & PRIORITY))
            cand = WRITE_REQ & PRIORITY;
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            if (!found && cand[(int'(last) + k) % WIDTH]) begin
                found  = 1'b1;
                winner = CH_W'((int'(last) + k) % WIDTH);
            end
        end
    end

    assign burst_hit  = (MAX_BURST != 0) && (burst_cnt == BURST_CAP) && !HOLD_REQ[g];
    assign pop        = (state == GRANT) && WRITE_REQ[g] && (!VALID_OUT || READY_IN) && !burst_hit;
    assign READ_GRANT = pop ? (WIDTH'(1) << g) : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            g           <= '0;
            last        <= CH_W'(WIDTH - 1);
            burst_cnt   <= '0;
            VALID_OUT   <= 1'b0;
            DATA_OUT    <= '0;
            CHANNEL_OUT <= '0;
            BUSY        <= 1'b0;
        end else begin
            // A pop with READY_IN high overwrites the accepted word in place.
            if (pop) begin
                DATA_OUT    <= DATA_IN[int'(g)*DATA_WIDTH +: DATA_WIDTH];
                CHANNEL_OUT <= g;
                VALID_OUT   <= 1'b1;
                if (burst_cnt != 16'hFFFF)
                    burst_cnt <= burst_cnt + 16'd1;
            end else if (READY_IN && VALID_OUT) begin
                VALID_OUT <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        g         <= winner;
                        burst_cnt <= '0;
                        state     <= GRANT;
                        BUSY      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (burst_hit || (!HOLD_REQ[g] && !WRITE_REQ[g])) begin
                        last  <= g;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized scoreboard bench for stream_rr_arbiter
// Channel FIFOs are queues; a transaction-level model predicts grants and output words.
module tb_stream_rr_arbiter;

    localparam int            W   = 4;
    localparam int            DW  = 32;
    localparam int            MB  = 2;
    localparam logic [W-1:0]  PRI = 4'b1000;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [W-1:0]    WRITE_REQ = '0;
    logic [W-1:0]    HOLD_REQ = '0;
    logic [W*DW-1:0] DATA_IN = '0;
    logic [W-1:0]    READ_GRANT;
    logic            READY_IN = 1'b1;
    logic            VALID_OUT;
    logic [DW-1:0]   DATA_OUT;
    logic [1:0]      CHANNEL_OUT;
    logic            BUSY;

    stream_rr_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .PRIORITY(PRI), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST), .WRITE_REQ(WRITE_REQ), .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN),
        .READ_GRANT(READ_GRANT), .READY_IN(READY_IN), .VALID_OUT(VALID_OUT),
        .DATA_OUT(DATA_OUT), .CHANNEL_OUT(CHANNEL_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int           total = 0;
    int           bad = 0;
    int           n_recv = 0;
    logic [31:0]  src [W][$];
    logic [31:0]  exp_d[$];
    int           exp_ch[$];
    int           gseq[$];
    int           seqn [W];
    logic [W-1:0] obs_grant;

    bit           rst_drv = 1'b1;
    logic [W-1:0] hold_drv = '0;
    logic [W-1:0] mask_drv = '1;
    bit           rdy_drv = 1'b1;

    bit m_busy = 0, m_valid = 0;
    int m_g = 0, m_last = W - 1, m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_n(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            src[ch].push_back((32'(ch) << 24) | (32'(seqn[ch]) & 32'h00FF_FFFF));
            seqn[ch]++;
        end
    endtask

    // Round-robin: the candidate nearest after the last released channel wins.
    function automatic int pick(input logic [W-1:0] c);
        int best = -1;
        int bd = W;
        for (int i = 0; i < W; i++) begin
            int d = (i - m_last - 1 + 2*W) % W;
            if (c[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic cycle();
        logic [W-1:0] wr, eg, c;
        bit hit, pop, was_busy;
        int w;
        @(negedge CLK);
        RST = rst_drv;
        HOLD_REQ = hold_drv;
        READY_IN = rdy_drv;
        for (int i = 0; i < W; i++) begin
            wr[i] = mask_drv[i] && (src[i].size() > 0);
            DATA_IN[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : '0;
        end
        WRITE_REQ = wr;
        #1;
        obs_grant = READ_GRANT;
        if (rst_drv) begin
            chk("rst_valid", 32'(VALID_OUT), 0);
            chk("rst_busy", 32'(BUSY), 0);
            chk("rst_grant", 32'(READ_GRANT), 0);
            chk("rst_data", DATA_OUT, 0);
            chk("rst_chan", 32'(CHANNEL_OUT), 0);
            m_busy = 0; m_valid = 0; m_last = W - 1; m_cnt = 0;
            exp_d.delete();
            exp_ch.delete();
        end else begin
            eg = '0; pop = 0; hit = 0;
            if (m_busy) begin
                hit = (MB != 0) && (m_cnt == MB) && !hold_drv[m_g];
                pop = wr[m_g] && (!m_valid || rdy_drv) && !hit;
                if (pop) eg[m_g] = 1'b1;
            end
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("valid", 32'(VALID_OUT), 32'(m_valid));
            chk("grant", 32'(READ_GRANT), 32'(eg));
            chk("onehot", 32'($countones(READ_GRANT) <= 1), 1);
            for (int i = 0; i < W; i++)
                if (READ_GRANT[i]) gseq.push_back(i);
            if (pop) begin
                exp_d.push_back(src[m_g].pop_front());
                exp_ch.push_back(m_g);
                m_valid = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (rdy_drv && m_valid) begin
                m_valid = 0;
            end
            was_busy = m_busy;
            if (was_busy) begin
                if (hit || (!hold_drv[m_g] && !wr[m_g])) begin
                    m_busy = 0;
                    m_last = m_g;
                end
            end else begin
                if (hold_drv != 0) c = hold_drv;
                else if ((wr & PRI) != 0) c = wr & PRI;
                else c = wr;
                w = pick(c);
                if (w >= 0) begin
                    m_busy = 1; m_g = w; m_cnt = 0;
                end
            end
        end
        if (bad >= 40) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    endtask

    always @(negedge CLK) begin
        #2;
        if (RST === 1'b0 && VALID_OUT && READY_IN) begin
            if (exp_d.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=%h required=no word", DATA_OUT);
            end else begin
                chk("sb_data", DATA_OUT, exp_d.pop_front());
                chk("sb_chan", 32'(CHANNEL_OUT), 32'(exp_ch.pop_front()));
                n_recv++;
            end
        end
    end

    task automatic wait_grant(input string name, input logic [W-1:0] want);
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (obs_grant != 0) break;
        end
        chk(name, 32'(obs_grant), 32'(want));
    endtask

    task automatic drain();
        int left;
        mask_drv = '1; hold_drv = '0; rdy_drv = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            cycle();
            left = exp_d.size();
            for (int i = 0; i < W; i++) left += src[i].size();
            if (left == 0 && !m_busy && !m_valid) break;
        end
        chk("drain_left", 32'(left), 0);
    endtask

    initial begin
        int n0, n2, nx, start;
        int expseq [6] = '{3, 3, 3, 1, 1, 1};

        repeat (3) cycle();
        rst_drv = 1'b0;

        // priority tier: ch3 served before ch1 until ch3 runs dry
        push_n(1, 3);
        push_n(3, 3);
        gseq.delete();
        wait_grant("prio_first", 4'b1000);
        drain();
        chk("prio_seq_len", 32'(gseq.size()), 6);
        for (int i = 0; i < 6 && i < gseq.size(); i++)
            chk($sformatf("prio_seq%0d", i), 32'(gseq[i]), 32'(expseq[i]));

        // hold: ch2 takes over at ch0 release and keeps grant past the burst cap
        push_n(0, 4);
        wait_grant("hold_pre", 4'b0001);
        hold_drv = 4'b0100;
        push_n(2, 5);
        push_n(1, 2);
        gseq.delete();
        repeat (14) cycle();
        n0 = 0; n2 = 0; nx = 0;
        foreach (gseq[i]) begin
            if (gseq[i] == 0) n0++;
            else if (gseq[i] == 2) n2++;
            else nx++;
        end
        chk("hold_ch0", 32'(n0), 1);
        chk("hold_ch2", 32'(n2), 5);
        chk("hold_other", 32'(nx), 0);
        chk("hold_busy", 32'(BUSY), 1);
        drain();

        // backpressure: word held stable while READY_IN is low
        rdy_drv = 1'b0;
        src[1].push_back(32'hDEADBEEF);
        src[1].push_back(32'h1111_1111);
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (VALID_OUT) break;
        end
        chk("bp_valid", 32'(VALID_OUT), 1);
        repeat (5) begin
            cycle();
            chk("bp_data", DATA_OUT, 32'hDEADBEEF);
            chk("bp_grant", 32'(obs_grant), 0);
        end
        rdy_drv = 1'b1;
        cycle();
        chk("bp_resume", 32'(obs_grant), 32'b0010);
        drain();

        // reset mid-burst, then lowest requesting channel wins
        push_n(0, 6);
        wait_grant("rst_pre", 4'b0001);
        push_n(2, 2);
        cycle();
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
        wait_grant("rst_first", 4'b0001);
        drain();

        // random traffic
        start = n_recv;
        for (int n = 0; n < 50000 && (n_recv - start) < 10000; n++) begin
            for (int ch = 0; ch < W; ch++)
                if ($urandom_range(11) == 0) push_n(ch, 1);
            if ($urandom_range(19) == 0)
                hold_drv = ($urandom_range(3) == 0) ? W'(1 << $urandom_range(W - 1)) : '0;
            mask_drv = ($urandom_range(9) == 0) ? W'($urandom) : '1;
            rdy_drv  = ($urandom_range(3) != 0);
            cycle();
        end
        chk("rand_words", 32'((n_recv - start) >= 10000), 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
